// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: state encoding,
// opcode/funct values, ALU operation codes and datapath select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JUMP_R   = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    // Code 0 is kept unused so an idle control word is all zeros.
    localparam logic [3:0] ALU_NONE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_NOR  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;

    localparam logic [1:0] REG_DST_RT = 2'd0;
    localparam logic [1:0] REG_DST_RD = 2'd1;
    localparam logic [1:0] REG_DST_RA = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] A_PC    = 2'd0;
    localparam logic [1:0] A_REG   = 2'd1;
    localparam logic [1:0] A_SHAMT = 2'd2;

    localparam logic [1:0] B_REG     = 2'd0;
    localparam logic [1:0] B_FOUR    = 2'd1;
    localparam logic [1:0] B_IMM     = 2'd2;
    localparam logic [1:0] B_IMM_SH2 = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    function automatic logic is_shift(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
    endfunction

    function automatic logic is_r_alu(input logic [5:0] fn);
        return is_shift(fn) || ((fn >= FN_ADD) && (fn <= FN_NOR)) ||
               (fn == FN_SLT) || (fn == FN_SLTU);
    endfunction

    function automatic logic is_i_alu(input logic [5:0] op);
        return (op >= OP_ADDI) && (op <= OP_LUI);
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation and immediate-extension decoder: R-type selects by funct,
// everything else by opcode.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       ext_sign
);

    always_comb begin
        alu_op   = ALU_ADD;
        ext_sign = 1'b1;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                FN_AND:          alu_op = ALU_AND;
                FN_OR:           alu_op = ALU_OR;
                FN_XOR:          alu_op = ALU_XOR;
                FN_NOR:          alu_op = ALU_NOR;
                FN_SLT:          alu_op = ALU_SLT;
                FN_SLTU:         alu_op = ALU_SLTU;
                FN_SLL:          alu_op = ALU_SLL;
                FN_SRL:          alu_op = ALU_SRL;
                FN_SRA:          alu_op = ALU_SRA;
                default:         alu_op = ALU_ADD;
            endcase
        end else begin
            // Logical immediates are zero-extended, all others sign-extended.
            case (opcode)
                OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
                OP_SLTI:           alu_op = ALU_SLT;
                OP_SLTIU:          alu_op = ALU_SLTU;
                OP_ANDI: begin alu_op = ALU_AND; ext_sign = 1'b0; end
                OP_ORI:  begin alu_op = ALU_OR;  ext_sign = 1'b0; end
                OP_XORI: begin alu_op = ALU_XOR; ext_sign = 1'b0; end
                OP_LUI:            alu_op = ALU_LUI;
                default:           alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM driving the shared PC/IR/ALU/memory datapath.
// Define MC_CTRL_PERF_EN to add the cycle_cnt/instr_cnt performance counters.
module mc_control
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 4,
    parameter int STATE_W  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_we,
    output logic                ir_we,
    output logic                iord,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                reg_we,
    output logic [1:0]          reg_dst,
    output logic [1:0]          wb_sel,
    output logic [1:0]          alu_a_sel,
    output logic [1:0]          alu_b_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                ext_sign,
    output logic [1:0]          pc_src,
    output logic                halted,
    output logic [STATE_W-1:0]  state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         instr_cnt
`endif
);

    state_t     cur, nxt;
    logic [3:0] alu_op_int;
    logic [3:0] dec_op;
    logic       dec_ext;

    mc_alu_dec u_alu_dec (
        .opcode   (opcode),
        .funct    (funct),
        .alu_op   (dec_op),
        .ext_sign (dec_ext)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cur <= S_START;
        else        cur <= nxt;
    end

    // Everything idles at zero unless the current step claims it, so START
    // and HALT (and an async abort into START) never leave a strobe high.
    always_comb begin
        nxt        = cur;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = REG_DST_RT;
        wb_sel     = WB_ALUOUT;
        alu_a_sel  = A_PC;
        alu_b_sel  = B_REG;
        alu_op_int = ALU_NONE;
        ext_sign   = 1'b0;
        pc_src     = PC_ALU;
        halted     = 1'b0;
        case (cur)
            S_START: nxt = S_FETCH;
            S_FETCH: begin
                mem_rd     = 1'b1;
                alu_b_sel  = B_FOUR;
                alu_op_int = ALU_ADD;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_b_sel  = B_IMM_SH2;
                ext_sign   = 1'b1;
                alu_op_int = ALU_ADD;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR)        nxt = S_JUMP_R;
                        else if (is_r_alu(funct))  nxt = S_EXEC_R;
                        else                       nxt = S_HALT;
                    end
                    OP_LW, OP_SW:   nxt = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: nxt = S_BRANCH;
                    OP_J, OP_JAL:   nxt = S_JUMP;
                    default:        nxt = is_i_alu(opcode) ? S_EXEC_I : S_HALT;
                endcase
            end
            S_EXEC_R: begin
                alu_a_sel  = is_shift(funct) ? A_SHAMT : A_REG;
                alu_op_int = dec_op;
                nxt        = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_a_sel  = A_REG;
                alu_b_sel  = B_IMM;
                alu_op_int = dec_op;
                ext_sign   = dec_ext;
                nxt        = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_we  = 1'b1;
                reg_dst = (opcode == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
                nxt     = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_a_sel  = A_REG;
                alu_b_sel  = B_IMM;
                ext_sign   = 1'b1;
                alu_op_int = ALU_ADD;
                nxt        = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (mem_ready) nxt = S_MEM_WB;
            end
            S_MEM_WR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (mem_ready) nxt = S_FETCH;
            end
            S_MEM_WB: begin
                reg_we = 1'b1;
                wb_sel = WB_MDR;
                nxt    = S_FETCH;
            end
            S_BRANCH: begin
                alu_a_sel  = A_REG;
                alu_op_int = ALU_SUB;
                pc_src     = PC_ALUOUT;
                pc_we      = (opcode == OP_BNE) ? ~zero : zero;
                nxt        = S_FETCH;
            end
            S_JUMP: begin
                pc_we  = 1'b1;
                pc_src = PC_JUMP;
                // PC already holds PC+4, which is the jal link value.
                if (opcode == OP_JAL) begin
                    reg_we  = 1'b1;
                    reg_dst = REG_DST_RA;
                    wb_sel  = WB_PC;
                end
                nxt = S_FETCH;
            end
            S_JUMP_R: begin
                pc_we  = 1'b1;
                pc_src = PC_REG;
                nxt    = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: nxt = S_START;
        endcase
    end

    assign alu_op = ALU_OP_W'(alu_op_int);
    assign state  = STATE_W'(cur);

`ifdef MC_CTRL_PERF_EN
    // A return to FETCH from any working state marks one retired instruction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (cur != S_START && cur != S_HALT)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (nxt == S_FETCH && cur != S_FETCH && cur != S_START)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_control.sv
// Randomized self-checking bench for mc_control: each instruction is expanded
// into its expected per-cycle step list and every cycle's outputs are checked.
module tb_mc_control;
    import mc_ctrl_pkg::*;

    localparam int ALU_OP_W = 4;
    localparam int STATE_W  = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [5:0]          opcode = '0;
    logic [5:0]          funct = '0;
    logic                zero = 1'b0;
    logic                mem_ready = 1'b0;
    logic                pc_we, ir_we, iord, mem_rd, mem_wr, reg_we;
    logic [1:0]          reg_dst, wb_sel, alu_a_sel, alu_b_sel, pc_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic                ext_sign, halted;
    logic [STATE_W-1:0]  state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0]         cycle_cnt, instr_cnt;
`endif

    typedef enum int {C_RALU, C_SHIFT, C_IALU, C_LW, C_SW, C_BEQ, C_BNE,
                      C_J, C_JAL, C_JR, C_HALT} iclass_t;
    typedef struct { state_t st; logic rdy; } step_t;

    step_t       q[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned ins = 0;

    mc_control #(.ALU_OP_W(ALU_OP_W), .STATE_W(STATE_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_we     (pc_we),
        .ir_we     (ir_we),
        .iord      (iord),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wb_sel    (wb_sel),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .alu_op    (alu_op),
        .ext_sign  (ext_sign),
        .pc_src    (pc_src),
        .halted    (halted),
        .state     (state)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] outVec();
        return 32'({pc_we, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst, wb_sel,
                    alu_a_sel, alu_b_sel, alu_op, ext_sign, pc_src, halted, state});
    endfunction

    // Reference ALU mapping for the ALU instructions this core supports.
    function automatic logic [3:0] refAluOp(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] r;
        r = ALU_ADD;
        if (op == OP_RTYPE) begin
            case (fn)
                6'h20, 6'h21: r = ALU_ADD;
                6'h22, 6'h23: r = ALU_SUB;
                6'h24: r = ALU_AND;
                6'h25: r = ALU_OR;
                6'h26: r = ALU_XOR;
                6'h27: r = ALU_NOR;
                6'h2A: r = ALU_SLT;
                6'h2B: r = ALU_SLTU;
                6'h00: r = ALU_SLL;
                6'h02: r = ALU_SRL;
                6'h03: r = ALU_SRA;
                default: r = ALU_ADD;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09: r = ALU_ADD;
                6'h0A: r = ALU_SLT;
                6'h0B: r = ALU_SLTU;
                6'h0C: r = ALU_AND;
                6'h0D: r = ALU_OR;
                6'h0E: r = ALU_XOR;
                6'h0F: r = ALU_LUI;
                default: r = ALU_ADD;
            endcase
        end
        return r;
    endfunction

    function automatic void pushMem(input state_t st, input int waits);
        for (int i = 0; i < waits; i++) q.push_back('{st, 1'b0});
        q.push_back('{st, 1'b1});
    endfunction

    function automatic void pushPlain(input state_t st);
        q.push_back('{st, 1'($urandom_range(0, 1))});
    endfunction

    task automatic checkCycle(input state_t st, input iclass_t cls, input logic rdy);
        logic take, isR, isJal;
        take  = (cls == C_BNE) ? ~zero : zero;
        isR   = (cls == C_RALU) || (cls == C_SHIFT);
        isJal = (cls == C_JAL);
        checkOutput("state", 32'(state), 32'(st));
        checkOutput("strobes", 32'({pc_we, ir_we, mem_rd, mem_wr, reg_we, halted}),
            32'({ (st == S_FETCH && rdy) || (st == S_BRANCH && take) ||
                  st == S_JUMP || st == S_JUMP_R,
                  st == S_FETCH && rdy,
                  st == S_FETCH || st == S_MEM_RD,
                  st == S_MEM_WR,
                  st == S_ALU_WB || st == S_MEM_WB || (st == S_JUMP && isJal),
                  st == S_HALT }));
        case (st)
            S_FETCH:    checkOutput("fetch_sel", 32'({iord, alu_a_sel, alu_b_sel, alu_op, pc_src}),
                                    32'({1'b0, 2'd0, 2'd1, ALU_ADD, 2'd0}));
            S_DECODE:   checkOutput("decode_sel", 32'({alu_a_sel, alu_b_sel, ext_sign, alu_op}),
                                    32'({2'd0, 2'd3, 1'b1, ALU_ADD}));
            S_EXEC_R:   checkOutput("exec_r_sel", 32'({alu_a_sel, alu_b_sel, alu_op}),
                                    32'({(cls == C_SHIFT) ? 2'd2 : 2'd1, 2'd0, refAluOp(opcode, funct)}));
            S_EXEC_I:   checkOutput("exec_i_sel", 32'({alu_a_sel, alu_b_sel, alu_op, ext_sign}),
                                    32'({2'd1, 2'd2, refAluOp(opcode, funct),
                                         !(opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E)}));
            S_ALU_WB:   checkOutput("alu_wb_sel", 32'({reg_dst, wb_sel}),
                                    32'({isR ? 2'd1 : 2'd0, 2'd0}));
            S_MEM_ADDR: checkOutput("mem_addr_sel", 32'({alu_a_sel, alu_b_sel, ext_sign, alu_op}),
                                    32'({2'd1, 2'd2, 1'b1, ALU_ADD}));
            S_MEM_RD, S_MEM_WR: checkOutput("mem_iord", 32'(iord), 32'd1);
            S_MEM_WB:   checkOutput("mem_wb_sel", 32'({reg_dst, wb_sel}), 32'({2'd0, 2'd1}));
            S_BRANCH:   checkOutput("branch_sel", 32'({alu_a_sel, alu_b_sel, alu_op, pc_src}),
                                    32'({2'd1, 2'd0, ALU_SUB, 2'd1}));
            S_JUMP: begin
                checkOutput("jump_src", 32'(pc_src), 32'd2);
                if (isJal) checkOutput("jal_link", 32'({reg_dst, wb_sel}), 32'({2'd2, 2'd2}));
            end
            S_JUMP_R:   checkOutput("jr_src", 32'(pc_src), 32'd3);
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input step_t s, input iclass_t cls, input logic last);
        mem_ready = s.rdy;
        @(negedge clock);
        checkCycle(s.st, cls, s.rdy);
`ifdef MC_CTRL_PERF_EN
        checkOutput("cycle_cnt", cycle_cnt, cyc);
        checkOutput("instr_cnt", instr_cnt, ins);
`endif
        @(posedge clock);
        #1;
        if (s.st != S_HALT) cyc++;
        if (last && s.st != S_HALT) ins++;
    endtask

    task automatic runInstr(input iclass_t cls, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int wf, input int wm);
        opcode = op;
        funct  = fn;
        zero   = z;
        q.delete();
        pushMem(S_FETCH, wf);
        pushPlain(S_DECODE);
        case (cls)
            C_RALU, C_SHIFT: begin pushPlain(S_EXEC_R); pushPlain(S_ALU_WB); end
            C_IALU:          begin pushPlain(S_EXEC_I); pushPlain(S_ALU_WB); end
            C_LW: begin pushPlain(S_MEM_ADDR); pushMem(S_MEM_RD, wm); pushPlain(S_MEM_WB); end
            C_SW: begin pushPlain(S_MEM_ADDR); pushMem(S_MEM_WR, wm); end
            C_BEQ, C_BNE:    pushPlain(S_BRANCH);
            C_J, C_JAL:      pushPlain(S_JUMP);
            C_JR:            pushPlain(S_JUMP_R);
            default: for (int i = 0; i < 11; i++) q.push_back('{S_HALT, 1'(i % 2)});
        endcase
        for (int i = 0; i < q.size(); i++) applyStimulus(q[i], cls, i == q.size() - 1);
    endtask

    task automatic doReset();
        #2 reset = 1'b0;
        #1 checkOutput("reset_outputs", outVec(), 32'd0);
        cyc = 0;
        ins = 0;
`ifdef MC_CTRL_PERF_EN
        checkOutput("reset_counters", {cycle_cnt | instr_cnt}, 32'd0);
`endif
        @(negedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic randomInstr();
        logic [5:0] rfn [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        logic [5:0] sfn [3]  = '{6'h00, 6'h02, 6'h03};
        iclass_t    c;
        logic [5:0] op, fn;
        c  = iclass_t'($urandom_range(0, 9));
        fn = 6'($urandom_range(0, 63));
        case (c)
            C_RALU:  begin op = 6'h00; fn = rfn[$urandom_range(0, 9)]; end
            C_SHIFT: begin op = 6'h00; fn = sfn[$urandom_range(0, 2)]; end
            C_IALU:  op = 6'($urandom_range(8, 15));
            C_LW:    op = 6'h23;
            C_SW:    op = 6'h2B;
            C_BEQ:   op = 6'h04;
            C_BNE:   op = 6'h05;
            C_J:     op = 6'h02;
            C_JAL:   op = 6'h03;
            default: begin op = 6'h00; fn = 6'h08; end
        endcase
        runInstr(c, op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    endtask

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        $display("[TB] mc_control bench starting");
        doReset();

        runInstr(C_RALU,  6'h00, 6'h20, 1'b0, 0, 0);
        runInstr(C_LW,    6'h23, 6'h11, 1'b0, 0, 2);
        runInstr(C_BEQ,   6'h04, 6'h00, 1'b1, 0, 0);
        runInstr(C_BEQ,   6'h04, 6'h00, 1'b0, 1, 0);
        runInstr(C_BNE,   6'h05, 6'h00, 1'b1, 0, 0);
        runInstr(C_BNE,   6'h05, 6'h00, 1'b0, 0, 0);
        runInstr(C_JAL,   6'h03, 6'h3F, 1'b0, 0, 0);
        runInstr(C_JR,    6'h00, 6'h08, 1'b0, 0, 0);
        runInstr(C_SW,    6'h2B, 6'h05, 1'b0, 2, 1);
        runInstr(C_SHIFT, 6'h00, 6'h03, 1'b0, 0, 0);
        runInstr(C_IALU,  6'h0D, 6'h00, 1'b0, 0, 0);
        runInstr(C_IALU,  6'h0A, 6'h00, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) randomInstr();

        // Abort a store while its write is outstanding.
        opcode = 6'h2B;
        funct  = 6'($urandom_range(0, 63));
        q.delete();
        pushMem(S_FETCH, 0);
        pushPlain(S_DECODE);
        pushPlain(S_MEM_ADDR);
        q.push_back('{S_MEM_WR, 1'b0});
        for (int i = 0; i < q.size(); i++) applyStimulus(q[i], C_SW, 1'b0);
        mem_ready = 1'b0;
        @(negedge clock);
        checkOutput("memwr_before_reset", 32'({state, mem_wr}), 32'({S_MEM_WR, 1'b1}));
        #2 reset = 1'b0;
        #1 checkOutput("abort_outputs", outVec(), 32'd0);
        cyc = 0;
        ins = 0;
        #1 reset = 1'b1;
        @(negedge clock);
        checkOutput("restart_fetch", 32'({state, mem_rd, iord}), 32'({S_FETCH, 1'b1, 1'b0}));
        @(posedge clock);
        #1;
        cyc++;

        runInstr(C_RALU, 6'h00, 6'h27, 1'b0, 0, 0);
        runInstr(C_HALT, 6'h00, 6'h0C, 1'b0, 0, 0);
        doReset();
        runInstr(C_IALU, 6'h0C, 6'h00, 1'b0, 1, 0);
        runInstr(C_HALT, 6'h3F, 6'h20, 1'b0, 0, 0);
        doReset();
        runInstr(C_HALT, 6'h00, 6'h01, 1'b0, 0, 0);
        doReset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
